// File: rtl/spi_master_block_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_block_pkg
// Purpose  : Shared constants and FSM state encoding for the SPI register
//            access master (spi_master_block) and its SCLK divider.
// Contents : DATA_WIDTH / ADDR_WIDTH, frame length, W/R bit values,
//            3-bit state encoding, command-word builder.
// Revision : 1.0 - initial release
// ============================================================================
package spi_master_block_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int ADDR_WIDTH     = 7;
  localparam int SPI_FRAME_BITS = 16;

  localparam logic SPI_WR_BIT = 1'b1;
  localparam logic SPI_RD_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Frame1 = {w/r, addr}, frame2 = data. Reads always shift out 0x00.
  function automatic logic [SPI_FRAME_BITS-1:0] build_cmd(
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] low;
    low = (wr == SPI_WR_BIT) ? data : '0;
    return {wr, addr, low};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_block_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Purpose  : SCLK half-period divider for spi_master_block.
// Ports    : i_clk, i_rst     - clock, synchronous active-high reset
//            i_en             - divider runs while high, held at 0 otherwise
//            i_shift_en       - SCLK phase tracking enabled (SHIFT state)
//            o_half_tick      - 1-cycle pulse on the last cycle of a half-period
//            o_rise_strobe    - half_tick that ends an SCLK-low half (SHIFT only)
//            o_fall_strobe    - half_tick that ends an SCLK-high half (SHIFT only)
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_shift_en,
  output logic o_half_tick,
  output logic o_rise_strobe,
  output logic o_fall_strobe
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic          phase_q;   // 0: SCLK-low half, 1: SCLK-high half

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Phase restarts low each time SHIFT is entered.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_shift_en) begin
      phase_q <= 1'b0;
    end else if (o_half_tick) begin
      phase_q <= ~phase_q;
    end
  end

  assign o_half_tick   = i_en && (div_cnt_q == DIV_LAST);
  assign o_rise_strobe = o_half_tick && i_shift_en && !phase_q;
  assign o_fall_strobe = o_half_tick && i_shift_en &&  phase_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_block.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_block
// Purpose  : SPI mode-0 master issuing a 16-bit register access
//            ({w/r, addr[6:0]} then data[7:0]) under one SSEL assertion,
//            with a start/busy/done local handshake.
// Ports    : i_clk, i_rst           - clock, synchronous active-high reset
//            i_start, i_wr, i_addr, i_wr_data - command (sampled when idle)
//            o_busy, o_done, o_rd_data        - status / read byte
//            o_SCLK, o_SSEL, o_MOSI, i_MISO   - SPI bus
//            i_loopback             - only with SPI_MASTER_LOOPBACK_EN defined:
//                                     sample MOSI instead of MISO
// Params   : CLK_DIV - i_clk cycles per SCLK half-period (>= 2)
// Macro    : SPI_MASTER_LOOPBACK_EN - enables the i_loopback self-test port
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_block
  import spi_master_block_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_SCLK,
  output logic                  o_SSEL,
  output logic                  o_MOSI,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  i_loopback,
`endif
  input  logic                  i_MISO
);

  generate
    if (CLK_DIV < 2) begin : g_clk_div_check
      $error("spi_master_block: CLK_DIV must be >= 2");
    end
  endgenerate

  spi_state_t                  state_q;
  logic [SPI_FRAME_BITS-1:0]   shift_q;
  logic [SPI_FRAME_BITS-1:0]   rx_q;
  logic [3:0]                  bit_cnt_q;
  logic                        busy_q;
  logic                        done_q;
  logic [DATA_WIDTH-1:0]       rd_data_q;
  logic                        sclk_q;
  logic                        ssel_q;
  logic                        mosi_q;

  logic                        w_half_tick;
  logic                        w_rise;
  logic                        w_fall;
  logic                        w_sample;
  logic [SPI_FRAME_BITS-1:0]   w_cmd;

  assign w_cmd = build_cmd(i_wr, i_addr, i_wr_data);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_sample = i_loopback ? mosi_q : i_MISO;
`else
  assign w_sample = i_MISO;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (state_q != ST_IDLE),
    .i_shift_en    (state_q == ST_SHIFT),
    .o_half_tick   (w_half_tick),
    .o_rise_strobe (w_rise),
    .o_fall_strobe (w_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      sclk_q    <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= ST_LEAD;
            shift_q   <= w_cmd;
            mosi_q    <= w_cmd[SPI_FRAME_BITS-1];
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            ssel_q    <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (w_half_tick) begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            sclk_q <= 1'b1;
            rx_q   <= (rx_q << 1) | SPI_FRAME_BITS'(w_sample);
          end
          if (w_fall) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q != 4'd15) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              shift_q   <= shift_q << 1;
              // Next bit is the one below the current MSB.
              mosi_q    <= shift_q[SPI_FRAME_BITS-2];
            end else begin
              state_q <= ST_TRAIL;
            end
          end
        end
        ST_TRAIL: begin
          if (w_half_tick) begin
            ssel_q  <= 1'b1;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_half_tick) begin
            rd_data_q <= rx_q[DATA_WIDTH-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            mosi_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_data = rd_data_q;
  assign o_SCLK    = sclk_q;
  assign o_SSEL    = ssel_q;
  assign o_MOSI    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_block
// Purpose  : Self-checking bench for spi_master_block (CLK_DIV=4) with a
//            behavioural mode-0 SPI slave on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_block;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       wr = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk, ssel, mosi;
  logic [7:0] rd_data;
  logic       miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master_block #(.CLK_DIV(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_wr      (wr),
    .i_addr    (addr),
    .i_wr_data (wdata),
    .o_busy    (busy),
    .o_done    (done),
    .o_rd_data (rd_data),
    .o_SCLK    (sclk),
    .o_SSEL    (ssel),
    .o_MOSI    (mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .i_loopback(loopback),
`endif
    .i_MISO    (miso)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [15:0] slave_tx = '0;
  logic [15:0] mosi_cap = '0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          done_cnt = 0;
  int          ssel_falls = 0;
  int          gap_run = 0;
  int          min_gap = 1000;
  bit          seen_low = 1'b0;

  always @(negedge ssel) begin
    rise_cnt = 0;
    fall_cnt = 0;
    mosi_cap = '0;
    ssel_falls++;
  end

  always @(posedge sclk) begin
    if (!ssel) begin
      mosi_cap = {mosi_cap[14:0], mosi};
      rise_cnt++;
    end
  end

  always @(negedge sclk) begin
    if (!ssel) fall_cnt++;
  end

  // Slave presents bit k of its frame while the master is on bit k.
  always @(negedge clk) begin
    if (!ssel && fall_cnt < 16) miso = slave_tx[4'(15 - fall_cnt)];
    else miso = 1'b0;
    if (done) done_cnt++;
    if (ssel) begin
      gap_run++;
    end else begin
      if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
      gap_run  = 0;
      seen_low = 1'b1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] slave;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[4];

  logic [15:0] r_mosi;
  logic [7:0]  r_rd;
  int          r_rises, r_lat, r_dones;

  // One transaction; optional stray start pulse at cycle ignore_at of busy.
  task automatic run_txn(input logic t_wr, input logic [6:0] t_addr,
                         input logic [7:0] t_data, input logic [15:0] t_slave,
                         input int ignore_at,
                         output logic [15:0] o_mosi, output logic [7:0] o_rd,
                         output int o_rises, output int o_lat, output int o_dones);
    int base;
    int lat;
    slave_tx = t_slave;
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; wr = t_wr; addr = t_addr; wdata = t_data;
    @(negedge clk);
    start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == ignore_at) begin
        start = 1'b1; wr = 1'b0; addr = 7'h7F; wdata = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    o_rd = rd_data;
    o_lat = lat;
    repeat (3) @(negedge clk);
    o_mosi  = mosi_cap;
    o_rises = rise_cnt;
    o_dones = done_cnt - base;
  endtask

  initial begin
    vecs[0] = '{1'b1, 7'h15, 8'hA5, 16'hFF5A, 16'h95A5, 8'h5A};
    vecs[1] = '{1'b0, 7'h03, 8'h00, 16'hE73C, 16'h0300, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'hFF, 16'h0000, 16'hFFFF, 8'h00};
    vecs[3] = '{1'b0, 7'h40, 8'hAB, 16'h1281, 16'h4000, 8'h81};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ssel", 32'(ssel), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd",   32'(rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].slave, -1,
              r_mosi, r_rd, r_rises, r_lat, r_dones);
      check($sformatf("v%0d_mosi", i), 32'(r_mosi), 32'(vecs[i].exp_mosi));
      check($sformatf("v%0d_rd", i), 32'(r_rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_rises", i), r_rises, 16);
      check($sformatf("v%0d_latency", i), r_lat, 140);
      check($sformatf("v%0d_dones", i), r_dones, 1);
    end

    // Busy-ignore: stray read start to addr 0x7F 10 cycles in
    run_txn(1'b1, 7'h15, 8'hA5, 16'h00C7, 10, r_mosi, r_rd, r_rises, r_lat, r_dones);
    check("bi_mosi", 32'(r_mosi), 32'h95A5);
    check("bi_rd", 32'(r_rd), 32'hC7);
    check("bi_rises", r_rises, 16);
    check("bi_latency", r_lat, 140);
    check("bi_dones", r_dones, 1);
    repeat (150) @(negedge clk);
    check("bi_no_second_txn", 32'(busy), 0);

    // Back-to-back with start held high
    begin
      int base_d, base_f, n;
      slave_tx = 16'h1281;
      @(posedge clk);
      min_gap = 1000; seen_low = 1'b0; gap_run = 0;
      base_d = done_cnt; base_f = ssel_falls;
      @(negedge clk);
      start = 1'b1; wr = 1'b1; addr = 7'h2A; wdata = 8'h55;
      n = 0;
      while ((done_cnt - base_d) < 2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      check("b2b_bounded", 32'(n < 1000), 1);
      n = 0;
      while (busy && n < 400) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
      check("b2b_txns_ge2", 32'((ssel_falls - base_f) >= 2), 1);
      check("b2b_done_per_txn", done_cnt - base_d, ssel_falls - base_f);
      check("b2b_gap_ge5", 32'(min_gap >= 5), 1);
      check("b2b_gap_seen", 32'(min_gap < 1000), 1);
      check("b2b_mosi", 32'(mosi_cap), 32'hAA55);
      check("b2b_rd", 32'(rd_data), 32'h81);
    end

    // Reset mid-transaction after the 6th SCLK rising edge
    begin
      int base_d, n;
      slave_tx = 16'hFFFF;
      base_d = done_cnt;
      @(negedge clk);
      start = 1'b1; wr = 1'b1; addr = 7'h15; wdata = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (rise_cnt < 6 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("rm_reached_edge6", 32'(rise_cnt), 6);
      rst = 1'b1;
      @(negedge clk);
      check("rm_ssel", 32'(ssel), 1);
      check("rm_sclk", 32'(sclk), 0);
      check("rm_mosi", 32'(mosi), 0);
      check("rm_busy", 32'(busy), 0);
      check("rm_rd",   32'(rd_data), 0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("rm_no_done", done_cnt - base_d, 0);
      run_txn(1'b0, 7'h03, 8'h77, 16'h003C, -1, r_mosi, r_rd, r_rises, r_lat, r_dones);
      check("rm_after_mosi", 32'(r_mosi), 32'h0300);
      check("rm_after_rd", 32'(r_rd), 32'h3C);
      check("rm_after_latency", r_lat, 140);
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    run_txn(1'b1, 7'h7F, 8'hC3, 16'h0000, -1, r_mosi, r_rd, r_rises, r_lat, r_dones);
    check("lb_mosi", 32'(r_mosi), 32'hFFC3);
    check("lb_rd", 32'(r_rd), 32'hC3);
    loopback = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_block.md
Name: spi_master_block

Overview:
- SPI master that issues the two-frame register-access protocol: frame1 = {w/r, addr[6:0]}, frame2 = data[7:0], with write=1 and read=0.
- Used to drive a remote register bank over SPI, for example a slave clock board or a test fixture for the local SPI register slave.
- The local side is a single-command start/busy/done handshake. Read data is captured from MISO during frame2.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, 16 bits per transaction under a single SSEL assertion.

Parameters:
- CLK_DIV, 4, i_clk cycles per SCLK half-period. Minimum 2; lower values are a compile-time error.

Ports:
- i_clk  in  1  system clock. Single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  command strobe. Sampled only while o_busy=0.
- i_wr  in  1  1=write, 0=read.
- i_addr  in  `ADDR_WIDTH (7)  register address.
- i_wr_data  in  `DATA_WIDTH (8)  write data. Don't-care on reads; 0x00 is still shifted out.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-cycle pulse at end of transaction.
- o_rd_data  out  `DATA_WIDTH  byte sampled from MISO in frame2. Held until the next o_done.
- o_SCLK  out  1  SPI clock. Idles low.
- o_SSEL  out  1  slave select, active-low. Idles high.
- o_MOSI  out  1  master out.
- i_MISO  in  1  master in. Assumed already synchronous, or registered once inside the block.

Behaviour:
- Reset values: o_SSEL=1, o_SCLK=0, o_MOSI=0, o_busy=0, o_done=0, o_rd_data=0x00. State returns to IDLE and all counters clear.
- Reset mid-transaction aborts immediately on the next edge with the values above. No o_done is produced.
- Command latch: when i_start=1 and o_busy=0, latch shift_reg = {i_wr, i_addr, i_wr_data}. For reads the low byte is 0x00.
- i_start while o_busy=1 is ignored; there is no queueing.
- Divider counter div_cnt counts 0..CLK_DIV-1 and is active only outside IDLE.
- Bit counter bit_cnt counts 0..15.
- States:
  - IDLE: o_busy=0. On an accepted start go to LEAD; o_busy=1, o_SSEL=0 and o_MOSI=shift_reg[15] all take effect on the next edge.
  - LEAD: wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT, first half-period: SCLK low. At its end SCLK rises and MISO is sampled into rx_reg (shift left, LSB in).
  - SHIFT, second half-period: SCLK high. At its end SCLK falls. If bit_cnt<15, advance MOSI to the next bit and increment bit_cnt; else go to TRAIL.
  - TRAIL: SCLK=0 and MOSI held for CLK_DIV cycles, then o_SSEL=1 and go to GAP.
  - GAP: SSEL stays high for CLK_DIV cycles. Then o_rd_data = rx_reg[7:0] (samples from bits 8..15), o_done=1 for one cycle, o_busy=0, and return to IDLE.
- Latency: o_done asserts exactly 35*CLK_DIV cycles after the first cycle with o_busy=1. This is 1 lead + 32 shift + 1 trail + 1 gap half-periods.
- Back-to-back commands: i_start may be asserted in the same cycle o_done is high. It is accepted in the following cycle, when o_busy=0.
- Guaranteed SSEL-high gap between transactions is ≥ CLK_DIV+1 cycles.
- Frame1 MISO bits go to rx_reg[15:8] and are discarded.
- o_rd_data updates on every transaction, writes included.
- Inputs i_wr, i_addr and i_wr_data are don't-care except in the start-accept cycle.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input i_loopback (1 bit). When i_loopback=1, the sample path uses the internally driven MOSI instead of i_MISO, giving an on-board self-test where o_rd_data equals the transmitted frame2 byte. o_SCLK, o_SSEL and o_MOSI still toggle normally.
- Undefined: the i_loopback port does not exist and MISO is always used.

Decomposition:
- Shared header spi_defs.vh holds:
  - SPI_FRAME_BITS = 16.
  - SPI_WR_BIT = 1 and SPI_RD_BIT = 0.
  - State encodings IDLE/LEAD/SHIFT/TRAIL/GAP (3-bit).
- DATA_WIDTH and ADDR_WIDTH continue to come from address_map.vh.
- One natural sub-module: spi_sclk_gen, holding the divider. It outputs single-cycle half_tick, rise_strobe and fall_strobe, with enable and sync reset.
- The FSM and shift registers stay in the top module.

Test Plan (CLK_DIV=4, behavioural SPI slave model on the bus):
- Write: start with i_wr=1, addr=0x15, data=0xA5 -> MOSI carries 0x95A5 MSB-first, 16 SCLK rising edges under one SSEL low; o_done exactly 140 cycles after o_busy rises.
- Read: start with i_wr=0, addr=0x03, slave returns 0x3C in frame2 -> MOSI = 0x0300; o_rd_data=0x3C at o_done; frame1 MISO value is ignored.
- Busy-ignore: a second i_start 10 cycles into a transaction with different addr -> no effect; exactly 16 SCLK edges; the original frame completes.
- Back-to-back: i_start held high continuously -> consecutive transactions with SSEL high ≥5 cycles between them; one o_done per transaction.
- Reset mid-op: i_rst pulsed after SCLK edge 6 -> next cycle SSEL=1, SCLK=0, MOSI=0, busy=0, o_rd_data=0x00; no o_done; a subsequent command runs normally.
- Loopback (SPI_MASTER_LOOPBACK_EN, i_loopback=1): write 0x7F/0xC3 with i_MISO tied 0 -> o_rd_data=0xC3.
